// File: rtl/lfsr_chk_pkg.sv
// Shared types and helpers for the multi-lane LFSR checker.
// Counter and word widths are limited to 64 bits by the helper functions.
package lfsr_chk_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lfsr_chk_state_t;

    // All-ones value of a w-bit counter, held in 64 bits.
    function automatic logic [63:0] cnt_max(input int w);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] v,
                                            input logic [63:0] inc,
                                            input logic [63:0] max_v);
        logic [64:0] sum;
        sum = {1'b0, v} + {1'b0, inc};
        if (sum > {1'b0, max_v}) return max_v;
        return sum[63:0];
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n = n + {6'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/lfsr.sv
// One-step Fibonacci LFSR successor: shifts left and inserts the tap parity.
// Supported widths are 2..64; widths without a listed polynomial fall back to the top two bits as taps.
module lfsr #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam logic [63:0] TAPS64 =
        (WIDTH == 8)  ? 64'h0000_0000_0000_00B8 :
        (WIDTH == 16) ? 64'h0000_0000_0000_D008 :
        (WIDTH == 32) ? 64'h0000_0000_8020_0003 :
        (WIDTH == 64) ? 64'hD800_0000_0000_0000 :
                        (64'd3 << (WIDTH - 2));
    localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(TAPS64);

    assign dout = {din[WIDTH-2:0], ^(din & TAP_MASK)};
endmodule

// File: rtl/lfsr_lane_checker.sv
// Single-lane LFSR checker: input register, compare stage, lock FSM with sticky error and counter.
// LFSR_CHK_BITERR_EN adds a delayed, saturating errored-bit counter.
module lfsr_lane_checker
    import lfsr_chk_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_CNT_W   = 16
`ifdef LFSR_CHK_BITERR_EN
    ,
    parameter int BIT_CNT_W   = 24
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 din_valid,
    input  logic [WIDTH-1:0]     din,
    output lfsr_chk_state_t      state_dbg,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef LFSR_CHK_BITERR_EN
    ,
    output logic [BIT_CNT_W-1:0] bit_err_cnt
`endif
);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_ERRS - 1);
    localparam logic [63:0]       ERR_MAX   = cnt_max(ERR_CNT_W);

    logic                  s1_valid;
    logic [WIDTH-1:0]      s1_data;
    logic [WIDTH-1:0]      s1_next;
    logic [WIDTH-1:0]      pred;
    logic                  have_prev;
    logic                  s2_valid;
    logic                  s2_bad;
    lfsr_chk_state_t       state, state_n;
    logic [GOOD_W-1:0]     good_run, good_run_n;
    logic [BAD_W-1:0]      bad_run, bad_run_n;
    logic                  error_n;
    logic [ERR_CNT_W-1:0]  err_cnt_n;
    logic                  count_err;
    logic                  restart;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) s1_data <= din;
        end
    end

    lfsr #(.WIDTH(WIDTH)) u_lfsr (
        .din  (s1_data),
        .dout (s1_next)
    );

    // A word arriving while the FSM drops lock only reseeds the prediction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred      <= '0;
            have_prev <= 1'b0;
            s2_valid  <= 1'b0;
            s2_bad    <= 1'b0;
        end else begin
            s2_valid <= s1_valid && have_prev && !restart;
            if (s1_valid) begin
                pred      <= s1_next;
                have_prev <= 1'b1;
                s2_bad    <= (s1_data != pred) || (s1_data == '0);
            end else if (restart) begin
                have_prev <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SEARCH;
            good_run <= '0;
            bad_run  <= '0;
            error    <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_n;
            good_run <= good_run_n;
            bad_run  <= bad_run_n;
            error    <= error_n;
            err_cnt  <= err_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        good_run_n = good_run;
        bad_run_n  = bad_run;
        count_err  = 1'b0;
        restart    = 1'b0;
        case (state)
            SEARCH: begin
                if (s2_valid && !s2_bad) begin
                    good_run_n = good_run + 1'b1;
                    if (good_run == GOOD_LAST) begin
                        state_n   = LOCKED;
                        bad_run_n = '0;
                    end
                end else if (s2_valid) begin
                    good_run_n = '0;
                end
            end
            LOCKED: begin
                if (s2_valid && s2_bad) begin
                    count_err = 1'b1;
                    bad_run_n = bad_run + 1'b1;
                    if (bad_run == BAD_LAST) begin
                        state_n    = SEARCH;
                        good_run_n = '0;
                        restart    = 1'b1;
                    end
                end else if (s2_valid) begin
                    bad_run_n = '0;
                end
            end
            default: state_n = SEARCH;
        endcase

        error_n   = error;
        err_cnt_n = err_cnt;
        if (clear) begin
            error_n   = 1'b0;
            err_cnt_n = '0;
        end else if (count_err) begin
            error_n   = 1'b1;
            err_cnt_n = ERR_CNT_W'(sat_add(64'(err_cnt), 64'd1, ERR_MAX));
        end
    end

`ifdef LFSR_CHK_BITERR_EN
    localparam logic [63:0] BIT_MAX = cnt_max(BIT_CNT_W);

    logic [WIDTH-1:0] s2_diff;
    logic             pc_valid;
    logic [6:0]       pc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_diff <= '0;
        end else if (s1_valid) begin
            s2_diff <= s1_data ^ pred;
        end
    end

    // Popcount is registered first, so the adder lands one cycle after err_cnt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_valid    <= 1'b0;
            pc_q        <= '0;
            bit_err_cnt <= '0;
        end else if (clear) begin
            pc_valid    <= 1'b0;
            bit_err_cnt <= '0;
        end else begin
            pc_valid <= count_err;
            pc_q     <= popcount(64'(s2_diff));
            if (pc_valid)
                bit_err_cnt <= BIT_CNT_W'(sat_add(64'(bit_err_cnt), 64'(pc_q), BIT_MAX));
        end
    end
`endif

endmodule

// File: rtl/lfsr_checker_mc.sv
// Multi-lane LFSR stream checker: LANES independent lane checkers plus an OR of their sticky errors.
// Define LFSR_CHK_BITERR_EN to add the per-lane bit_err_cnt port and popcount logic.
module lfsr_checker_mc
    import lfsr_chk_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LANES       = 4,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_ERRS = 4,
    parameter int ERR_CNT_W   = 16
`ifdef LFSR_CHK_BITERR_EN
    ,
    parameter int BIT_CNT_W   = 24
`endif
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic [LANES-1:0]           datain_valid,
    input  logic [LANES*WIDTH-1:0]     datain,
    output logic [LANES-1:0]           locked,
    output logic [LANES-1:0]           error,
    output logic                       any_error,
    output logic [LANES*ERR_CNT_W-1:0] err_cnt
`ifdef LFSR_CHK_BITERR_EN
    ,
    output logic [LANES*BIT_CNT_W-1:0] bit_err_cnt
`endif
);
    lfsr_chk_state_t lane_state [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lfsr_lane_checker #(
            .WIDTH       (WIDTH),
            .LOCK_CNT    (LOCK_CNT),
            .UNLOCK_ERRS (UNLOCK_ERRS),
            .ERR_CNT_W   (ERR_CNT_W)
`ifdef LFSR_CHK_BITERR_EN
            ,
            .BIT_CNT_W   (BIT_CNT_W)
`endif
        ) u_lane (
            .clk         (clk),
            .reset_n     (reset_n),
            .clear       (clear),
            .din_valid   (datain_valid[i]),
            .din         (datain[i*WIDTH +: WIDTH]),
            .state_dbg   (lane_state[i]),
            .error       (error[i]),
            .err_cnt     (err_cnt[i*ERR_CNT_W +: ERR_CNT_W])
`ifdef LFSR_CHK_BITERR_EN
            ,
            .bit_err_cnt (bit_err_cnt[i*BIT_CNT_W +: BIT_CNT_W])
`endif
        );

        assign locked[i] = (lane_state[i] == LOCKED);
    end

    assign any_error = |error;

endmodule

// File: tb/tb_lfsr_checker_mc.sv
// Self-checking bench for lfsr_checker_mc: table-driven lock/error/unlock vectors on lane 0,
// plus hand sequences for gaps, saturation with clear, all-zero words and async reset.
module tb_lfsr_checker_mc;
    localparam int W     = 32;
    localparam int LANES = 4;
    localparam logic [1:0] K_IDLE    = 2'd0;
    localparam logic [1:0] K_CLEAN   = 2'd1;
    localparam logic [1:0] K_CORRUPT = 2'd2;
    localparam logic [1:0] K_RAND    = 2'd3;

    logic                 clk;
    logic                 reset_n;
    logic                 clear;
    logic [LANES-1:0]     valid;
    logic [LANES*W-1:0]   data;
    logic [LANES-1:0]     locked;
    logic [LANES-1:0]     error;
    logic                 any_error;
    logic [LANES*16-1:0]  err_cnt;

    logic                 clear2;
    logic [0:0]           valid2;
    logic [W-1:0]         data2;
    logic [0:0]           locked2;
    logic [0:0]           error2;
    logic                 any2;
    logic [3:0]           err_cnt2;
`ifdef LFSR_CHK_BITERR_EN
    logic [LANES*24-1:0]  bit_err_cnt;
    logic [23:0]          bit2;
`endif

    int          n_tests;
    int          n_fail;
    int          rand_n;
    logic [31:0] cur [LANES];
    logic [31:0] cur2;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [1:0]  kind;
        logic        exp_locked;
        logic        exp_error;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs [36];

    lfsr_checker_mc dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .datain_valid (valid),
        .datain       (data),
        .locked       (locked),
        .error        (error),
        .any_error    (any_error),
        .err_cnt      (err_cnt)
`ifdef LFSR_CHK_BITERR_EN
        ,
        .bit_err_cnt  (bit_err_cnt)
`endif
    );

    lfsr_checker_mc #(.LANES(1), .ERR_CNT_W(4)) dut_sat (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear2),
        .datain_valid (valid2),
        .datain       (data2),
        .locked       (locked2),
        .error        (error2),
        .any_error    (any2),
        .err_cnt      (err_cnt2)
`ifdef LFSR_CHK_BITERR_EN
        ,
        .bit_err_cnt  (bit2)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    function automatic logic [31:0] make_word(input logic [1:0] kind, inout logic [31:0] st,
                                              inout int rn);
        logic [31:0] w;
        w = '0;
        case (kind)
            K_CLEAN, K_CORRUPT: begin
                st = lfsr_next(st);
                w  = st;
                if (kind == K_CORRUPT) w[5] = ~w[5];
            end
            K_RAND: begin
                w  = 32'hA5A5_0000 + 32'(rn);
                rn = rn + 1;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic drive_lane(input int l, input logic [1:0] kind);
        logic [31:0] st;
        logic [31:0] w;
        int rn;
        st = cur[l];
        rn = rand_n;
        w = make_word(kind, st, rn);
        cur[l] = st;
        rand_n = rn;
        valid[l] = (kind != K_IDLE);
        data[l*W +: W] = w;
    endtask

    task automatic drive_zero(input int l);
        valid[l] = 1'b1;
        data[l*W +: W] = '0;
    endtask

    task automatic drive_sat(input logic [1:0] kind);
        logic [31:0] st;
        int rn;
        st = cur2;
        rn = rand_n;
        data2 = make_word(kind, st, rn);
        cur2 = st;
        rand_n = rn;
        valid2 = (kind != K_IDLE);
    endtask

    // Advance one edge, sample 1 ns later, then return all strobes to idle.
    task automatic step();
        @(posedge clk);
        #1;
        valid  = '0;
        valid2 = '0;
        clear  = 1'b0;
        clear2 = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int lo, input int hi, input logic [1:0] kind,
                        input logic l, input logic e, input logic [15:0] c);
        for (int i = lo; i <= hi; i++) begin
            vecs[i].kind       = kind;
            vecs[i].exp_locked = l;
            vecs[i].exp_error  = e;
            vecs[i].exp_cnt    = c;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rand_n  = 1;
        clear   = 1'b0;
        clear2  = 1'b0;
        valid   = '0;
        valid2  = '0;
        data    = '0;
        data2   = '0;
        reset_n = 1'b1;
        for (int i = 0; i < LANES; i++) cur[i] = 32'h1234_5678 + 32'(i) * 32'h0101_1111;
        cur2 = 32'hCAFE_F00D;

        // Row r is sampled at edge r; its effect shows after edge r+2.
        fill(0,  9,  K_CLEAN,   1'b0, 1'b0, 16'd0);
        fill(10, 13, K_CLEAN,   1'b1, 1'b0, 16'd0);
        fill(14, 14, K_CORRUPT, 1'b1, 1'b0, 16'd0);
        fill(15, 15, K_CLEAN,   1'b1, 1'b0, 16'd0);
        fill(16, 16, K_CLEAN,   1'b1, 1'b1, 16'd1);
        fill(17, 19, K_CLEAN,   1'b1, 1'b1, 16'd2);
        fill(20, 21, K_RAND,    1'b1, 1'b1, 16'd2);
        fill(22, 22, K_RAND,    1'b1, 1'b1, 16'd3);
        fill(23, 23, K_RAND,    1'b1, 1'b1, 16'd4);
        fill(24, 24, K_CLEAN,   1'b1, 1'b1, 16'd5);
        fill(25, 33, K_CLEAN,   1'b0, 1'b1, 16'd6);
        fill(34, 35, K_CLEAN,   1'b1, 1'b1, 16'd6);

        apply_reset();
        #1;
        check("rst_locked",   64'(locked),    64'd0);
        check("rst_error",    64'(error),     64'd0);
        check("rst_any",      64'(any_error), 64'd0);
        check("rst_err_cnt",  64'(err_cnt),   64'd0);
        check("rst_locked2",  64'(locked2),   64'd0);
        check("rst_err_cnt2", 64'(err_cnt2),  64'd0);
`ifdef LFSR_CHK_BITERR_EN
        check("rst_bit_cnt",  64'(bit_err_cnt), 64'd0);
`endif

        // Lock, single corruption, unlock by random words, relock on lane 0.
        for (int r = 0; r < 36; r++) begin
            drive_lane(0, vecs[r].kind);
            step();
            check($sformatf("tbl%0d_locked0", r), 64'(locked[0]),   64'(vecs[r].exp_locked));
            check($sformatf("tbl%0d_error0", r),  64'(error[0]),    64'(vecs[r].exp_error));
            check($sformatf("tbl%0d_any", r),     64'(any_error),   64'(vecs[r].exp_error));
            check($sformatf("tbl%0d_cnt0", r),    64'(err_cnt[15:0]), 64'(vecs[r].exp_cnt));
            check($sformatf("tbl%0d_others", r),
                  {16'd0, err_cnt[63:16]} | 64'(locked[3:1]) | 64'(error[3:1]), 64'd0);
`ifdef LFSR_CHK_BITERR_EN
            if (r == 17) check("tbl17_bit_cnt0", 64'(bit_err_cnt[23:0]), 64'd1);
            if (r == 18) check("tbl18_bit_cnt0", 64'(bit_err_cnt[23:0]), 64'd2);
`endif
        end

        // Lane 1 with a gap every other cycle: lock counts only valid words.
        for (int r = 0; r < 22; r++) begin
            if (r % 2 == 0) drive_lane(1, K_CLEAN);
            step();
            check($sformatf("gap%0d_locked1", r), 64'(locked[1]), (r >= 18) ? 64'd1 : 64'd0);
            check($sformatf("gap%0d_err1", r),
                  64'(error[1]) | 64'(err_cnt[31:16]), 64'd0);
        end
        check("gap_hold_locked0", 64'(locked[0]), 64'd1);
        check("gap_hold_cnt0",    64'(err_cnt[15:0]), 64'd6);

        // Saturation of a 4-bit counter over 20 isolated errors.
        for (int r = 0; r < 11; r++) begin
            drive_sat(K_CLEAN);
            step();
        end
        check("sat_locked", 64'(locked2), 64'd1);
        for (int g = 0; g < 20; g++) begin
            drive_sat(K_CORRUPT);
            step();
            if (g > 0) check($sformatf("sat_grp%0d_cnt", g - 1), 64'(err_cnt2), 64'(exp_q.pop_front()));
            exp_q.push_back((2 * (g + 1) > 15) ? 16'd15 : 16'(2 * (g + 1)));
            drive_sat(K_CLEAN);
            step();
            drive_sat(K_CLEAN);
            step();
        end
        drive_sat(K_CLEAN);
        step();
        check("sat_grp19_cnt", 64'(err_cnt2), 64'(exp_q.pop_front()));
        check("sat_error",     64'(error2),   64'd1);
        check("sat_any",       64'(any2),     64'd1);

        // Clear held over the two edges where the corrupted pair's results land.
        drive_sat(K_CORRUPT);
        step();
        drive_sat(K_CLEAN);
        step();
        drive_sat(K_CLEAN);
        clear2 = 1'b1;
        step();
        drive_sat(K_CLEAN);
        clear2 = 1'b1;
        step();
        check("clr_cnt",    64'(err_cnt2), 64'd0);
        check("clr_error",  64'(error2),   64'd0);
        check("clr_any",    64'(any2),     64'd0);
        check("clr_locked", 64'(locked2),  64'd1);
        drive_sat(K_CLEAN);
        step();
        check("clr_after_cnt", 64'(err_cnt2), 64'd0);
`ifdef LFSR_CHK_BITERR_EN
        check("clr_bit_cnt", 64'(bit2), 64'd0);
`endif

        // All-zero words on lane 3 while lane 0 locks and takes an error.
        apply_reset();
        for (int r = 0; r < 18; r++) begin
            drive_zero(3);
            drive_lane(0, (r == 14) ? K_CORRUPT : K_CLEAN);
            step();
            check($sformatf("zero%0d_lane3", r),
                  64'(locked[3]) | 64'(error[3]) | 64'(err_cnt[63:48]), 64'd0);
        end
        check("pre_rst_locked0", 64'(locked[0]), 64'd1);
        check("pre_rst_error0",  64'(error[0]),  64'd1);
        check("pre_rst_cnt0",    64'(err_cnt[15:0]), 64'd2);

        // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
        #3 reset_n = 1'b0;
        #1;
        check("async_locked",  64'(locked),    64'd0);
        check("async_error",   64'(error),     64'd0);
        check("async_any",     64'(any_error), 64'd0);
        check("async_err_cnt", 64'(err_cnt),   64'd0);
`ifdef LFSR_CHK_BITERR_EN
        check("async_bit_cnt", 64'(bit_err_cnt), 64'd0);
`endif
        #2 reset_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            drive_lane(0, K_CLEAN);
            step();
            check($sformatf("post_rst%0d_lane0", r),
                  64'(locked[0]) | 64'(error[0]) | 64'(err_cnt[15:0]), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_checker_mc.md
# lfsr_checker_mc

Multi-lane, parametrised successor of the single-lane 32-bit LFSR checker. Each lane checks a self-synchronising LFSR stream, acquires and tracks lock, and keeps a sticky error flag and a saturating error counter. Sits at the receive end of the heater/loopback test paths, one lane per data channel. Results feed status registers through `locked`, `error` and `err_cnt`.

## Interface
Parameters:
- `WIDTH`, 32: LFSR/data word width per lane; passed to `lfsr #(.WIDTH)`.
- `LANES`, 4: number of independent lanes, minimum 1.
- `LOCK_CNT`, 8: consecutive good comparisons needed to declare lock, minimum 1.
- `UNLOCK_ERRS`, 4: consecutive bad comparisons while locked that drop lock, minimum 1.
- `ERR_CNT_W`, 16: width of each lane's error counter.
- `BIT_CNT_W`, 24: width of each lane's bit-error counter; used only with `LFSR_CHK_BITERR_EN`.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of counters and sticky flags.
- `datain_valid` in LANES: per-lane word strobe.
- `datain` in LANES*WIDTH: lane i occupies `[i*WIDTH +: WIDTH]`.
- `locked` out LANES: lane is in LOCKED.
- `error` out LANES: sticky per-lane error flag.
- `any_error` out 1: OR of `error`.
- `err_cnt` out LANES*ERR_CNT_W: per-lane error count, same packing as `datain`.
- `bit_err_cnt` out LANES*BIT_CNT_W: per-lane errored-bit count; present only with the macro.

## Operation
- Each lane predicts each word as `lfsr(previous valid word)`. Its state is one register `state` ∈ {SEARCH, LOCKED}, plus `have_prev`, `good_run` and `bad_run`.
- Only cycles with `datain_valid[i]`=1 are processed. Gaps hold all lane state. After a gap, the next word is compared against the prediction from the last valid word.
- The first valid word after reset has no comparison and only loads the prediction. The same applies to the first valid word after entry to SEARCH.
- A word is bad if it differs from the prediction. An all-zero word is always bad, because it is the LFSR lock-up state.
- SEARCH:
  - A good word increments `good_run`.
  - A bad word zeroes `good_run`. It sets no error and does not change the counter.
  - When `good_run` reaches LOCK_CNT, go to LOCKED and zero `bad_run`.
- LOCKED:
  - A bad word sets `error[i]`, increments `err_cnt[i]` and increments `bad_run`.
  - A good word zeroes `bad_run`.
  - When `bad_run` reaches UNLOCK_ERRS, go to SEARCH, zero `good_run` and clear `have_prev`.
- `err_cnt` saturates at all-ones and never wraps.
- `clear`:
  - Zeroes `err_cnt`, `error` and `bit_err_cnt` on all lanes.
  - Does not change `state`, the run counters or the prediction.
  - Wins over a same-cycle error: the error is dropped from both the flags and the counters.
- Lanes are fully independent. Simultaneous events on different lanes never interact.

## Timing
- Reset values: `locked`=0, `error`=0, `any_error`=0, `err_cnt`=0, `bit_err_cnt`=0. All lanes start in SEARCH with `have_prev`=0.
- Pipeline:
  - Stage 1 registers `datain`/`datain_valid`.
  - Stage 2 registers the comparison result.
  - Stage 3 registers `state` and the counters.
- A word sampled at edge t affects the outputs visible after edge t+2.
- `any_error` is combinational from the `error` registers and has the same latency.
- `clear` sampled at edge t zeroes its outputs after edge t. A comparison result that lands at edge t is discarded.
- `reset_n` asserted mid-stream returns everything to reset values asynchronously. All pipeline contents are discarded.

## Configuration
- `LFSR_CHK_BITERR_EN` defined:
  - Each lane adds a popcount of `datain ^ prediction` to `bit_err_cnt[i]`.
  - The count is taken only on bad words in LOCKED, and saturates at all-ones.
  - The adder path gets one extra register, so `bit_err_cnt` lags `err_cnt` by one cycle.
  - `clear` zeroes it at the same edge as the other counters.
- Macro undefined: the `bit_err_cnt` port and all popcount logic are absent.

## Structure
- Package `lfsr_chk_pkg` holds:
  - The state enum `lfsr_chk_state_t` {SEARCH, LOCKED}.
  - Saturating-increment and popcount functions.
- Sub-module `lfsr_lane_checker` is a single-lane pipeline plus state machine that instantiates `lfsr #(.WIDTH)`.
- The top generates LANES instances and ORs `any_error`.

## Test plan
- Reset, then a clean LFSR stream on lane 0 with valid held high → `locked[0]`=1 exactly 2 cycles after the (LOCK_CNT+1)th word; `err_cnt[0]`=0; other lanes stay 0.
- Once locked, flip bit 5 of one word → `error[0]`=1 and `err_cnt[0]`=2, because the corrupted word and its successor both miscompare. With the macro, `bit_err_cnt[0]`=2 one cycle after `err_cnt`.
- Once locked, send UNLOCK_ERRS consecutive random words → `locked[0]` drops. It relocks after the clean stream resumes plus LOCK_CNT+1 words.
- Drive `datain_valid` with alternating gaps over a clean stream → no errors, and lock is achieved counting only valid words.
- Set ERR_CNT_W=4 and inject 20 isolated errors → `err_cnt`=15 saturated. `clear` together with an error at the same edge → `err_cnt`=0 and `error`=0, while `locked` is unchanged.
- Feed all-zero words while in SEARCH → lane never locks and `error` stays 0. Assert `reset_n` low mid-stream → all outputs 0 immediately.
